// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - word handshake between producer logic and the buffered UART transmitter
interface uart_tx_buffered_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered UART transmitter, start + WIDTH data (LSB first) + STOP_BITS stop
module uart_tx_buffered #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    uart_tx_buffered_if.slave             in_if,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int TICKS = CLOCK_FREQ / BAUD_RATE;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int TW    = (TICKS > 2) ? $clog2(TICKS) : 1;
    localparam int BW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] FULL       = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
    localparam logic          STOP_LAST  = (STOP_BITS == 2);

    generate
        if (TICKS < 2) begin : g_bad_ticks
            $fatal(1, "uart_tx_buffered: CLOCK_FREQ / BAUD_RATE must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $fatal(1, "uart_tx_buffered: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "uart_tx_buffered: FIFO_DEPTH must be a power of two, at least 2");
        end
        if (WIDTH < 2) begin : g_bad_width
            $fatal(1, "uart_tx_buffered: WIDTH must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] shift;
    logic [TW-1:0]    tick;
    logic [BW-1:0]    bit_idx;
    logic             stop_idx;
    logic             push;
    logic             pop;

    // Full blocks the producer even when a pop happens on the same edge.
    assign in_if.in_ready = (fifo_count != FULL);
    assign push           = in_if.in_valid && in_if.in_ready;

    // The FSM takes the head word when idle, or at the end of the last stop bit for back-to-back frames.
    always_comb begin
        pop = 1'b0;
        if (fifo_count != '0) begin
            case (state)
                IDLE:    pop = 1'b1;
                STOP:    pop = (tick == '0) && (stop_idx == STOP_LAST);
                default: pop = 1'b0;
            endcase
        end
    end

    // Word storage; no reset needed since occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_if.in_data;
        end
    end

    // Circular-buffer pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame sequencer: every bit lasts TICKS cycles, tx and busy are registered here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            shift    <= '0;
            tick     <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        tick  <= TICK_LAST;
                        state <= START;
                    end
                end
                START: begin
                    if (tick == '0) begin
                        tx      <= shift[0];
                        bit_idx <= '0;
                        tick    <= TICK_LAST;
                        state   <= DATA;
                    end else begin
                        tick <= tick - 1'b1;
                    end
                end
                DATA: begin
                    if (tick == '0) begin
                        tick <= TICK_LAST;
                        if (bit_idx != BIT_LAST) begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end else begin
                            tx       <= 1'b1;
                            stop_idx <= 1'b0;
                            state    <= STOP;
                        end
                    end else begin
                        tick <= tick - 1'b1;
                    end
                end
                STOP: begin
                    if (tick == '0) begin
                        if (stop_idx != STOP_LAST) begin
                            stop_idx <= 1'b1;
                            tick     <= TICK_LAST;
                        end else if (pop) begin
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                            tick  <= TICK_LAST;
                            state <= START;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        tick <= tick - 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered (STOP_BITS 1 and 2 side by side)
module tb_uart_tx_buffered;
    localparam int CF = 1_000_000;
    localparam int BR = 100_000;
    localparam int T  = 10;
    localparam int W  = 8;
    localparam int D  = 4;

    logic         clock     = 1'b0;
    logic         reset     = 1'b1;
    logic [W-1:0] drv_data  = '0;
    logic         drv_valid = 1'b0;
    logic [1:0]   tx_o;
    logic [1:0]   busy_o;
    logic [1:0]   rdy_o;
    logic [2:0]   cnt_o [2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    uart_tx_buffered_if #(.WIDTH(W)) bus0 ();
    uart_tx_buffered_if #(.WIDTH(W)) bus1 ();

    assign bus0.in_data  = drv_data;
    assign bus0.in_valid = drv_valid;
    assign bus1.in_data  = drv_data;
    assign bus1.in_valid = drv_valid;
    assign rdy_o         = {bus1.in_ready, bus0.in_ready};

    uart_tx_buffered #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .WIDTH(W), .FIFO_DEPTH(D), .STOP_BITS(1)) dut0 (
        .clock(clock), .reset(reset), .in_if(bus0.slave),
        .tx(tx_o[0]), .busy(busy_o[0]), .fifo_count(cnt_o[0])
    );

    uart_tx_buffered #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .WIDTH(W), .FIFO_DEPTH(D), .STOP_BITS(2)) dut1 (
        .clock(clock), .reset(reset), .in_if(bus1.slave),
        .tx(tx_o[1]), .busy(busy_o[1]), .fifo_count(cnt_o[1])
    );

    // model: buffered words, words awaiting decode, frame in flight and its cycle position
    logic [W-1:0] mq [2][$];
    logic [W-1:0] sq [2][$];
    logic [W-1:0] cur [2];
    int           pos [2];
    bit           act [2];

    // receiver model state
    bit           rx_on [2];
    int           rx_c [2];
    logic [W-1:0] rx_w [2];
    int           n_rx [2];

    // stimulus and recorded waveforms
    logic [W-1:0] stim [$];
    logic         wv [2][400];
    logic         bv [2][400];
    int           cv [2][400];
    int           a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    task automatic chk(input string name, input int got, input int exp);
        n_assert++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int flen(input int i);
        return (1 + W + ((i == 0) ? 1 : 2)) * T;
    endfunction

    function automatic logic exp_tx(input int i);
        int k;
        if (!act[i]) return 1'b1;
        k = pos[i] / T;
        if (k == 0) return 1'b0;
        if (k <= W) return cur[i][k-1];
        return 1'b1;
    endfunction

    // model update on every active edge: frame end/start first, then the producer's push
    initial begin
        bit ready;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                for (int i = 0; i < 2; i++) begin
                    mq[i].delete();
                    sq[i].delete();
                    act[i] = 1'b0;
                    pos[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    ready = (mq[i].size() != D);
                    if (act[i]) begin
                        pos[i]++;
                        if (pos[i] == flen(i)) act[i] = 1'b0;
                    end
                    if (!act[i] && mq[i].size() > 0) begin
                        cur[i] = mq[i].pop_front();
                        pos[i] = 0;
                        act[i] = 1'b1;
                    end
                    if (drv_valid && ready) begin
                        mq[i].push_back(drv_data);
                        sq[i].push_back(drv_data);
                    end
                end
            end
        end
    end

    // per-cycle compare against the model plus a mid-bit sampling receiver
    initial begin
        int k;
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                if (reset) begin
                    rx_on[i] = 1'b0;
                end else begin
                    chk($sformatf("tx%0d", i), int'(tx_o[i]), int'(exp_tx(i)));
                    chk($sformatf("busy%0d", i), int'(busy_o[i]), int'(act[i]));
                    chk($sformatf("count%0d", i), int'(cnt_o[i]), mq[i].size());
                    chk($sformatf("ready%0d", i), int'(rdy_o[i]), int'(mq[i].size() != D));
                    if (!rx_on[i]) begin
                        if (tx_o[i] == 1'b0) begin
                            rx_on[i] = 1'b1;
                            rx_c[i]  = 0;
                        end
                    end else begin
                        rx_c[i]++;
                        if (rx_c[i] % T == T / 2) begin
                            k = rx_c[i] / T;
                            if (k >= 1 && k <= W) begin
                                rx_w[i][k-1] = tx_o[i];
                            end else if (k == W + 1) begin
                                chk($sformatf("rx_stop%0d", i), int'(tx_o[i]), 1);
                                if (sq[i].size() == 0) chk($sformatf("rx_extra%0d", i), 1, 0);
                                else chk($sformatf("rx_word%0d", i), int'(rx_w[i]), int'(sq[i].pop_front()));
                                n_rx[i]++;
                                rx_on[i] = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_assert);
        $fatal(1, "watchdog expired");
    end

    // present stim words on consecutive edges 0.., record outputs after each edge
    task automatic run(input int n);
        @(negedge clock);
        #2;
        if (stim.size() > 0) begin
            drv_data  = stim[0];
            drv_valid = 1'b1;
        end
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                wv[i][c] = tx_o[i];
                bv[i][c] = busy_o[i];
                cv[i][c] = int'(cnt_o[i]);
            end
            #2;
            if (c + 1 < stim.size()) drv_data = stim[c+1];
            else drv_valid = 1'b0;
        end
    endtask

    task automatic drain(input int max_cycles);
        int c;
        c = 0;
        while ((act[0] || act[1] || mq[0].size() > 0 || mq[1].size() > 0 ||
                sq[0].size() > 0 || sq[1].size() > 0) && c < max_cycles) begin
            @(negedge clock);
            c++;
        end
        chk("drain_timeout", int'(c >= max_cycles), 0);
        repeat (3) @(negedge clock);
    endtask

    function automatic int busy_sum(input int i, input int n);
        int s = 0;
        for (int c = 0; c < n; c++) s += int'(bv[i][c]);
        return s;
    endfunction

    function automatic int busy_high_sum(input int i, input int n);
        int s = 0;
        for (int c = 0; c < n; c++) s += int'(bv[i][c] && wv[i][c]);
        return s;
    endfunction

    function automatic int low_sum(input int i, input int n);
        int s = 0;
        for (int c = 0; c < n; c++) s += int'(!wv[i][c]);
        return s;
    endfunction

    function automatic int busy_rises(input int i, input int n);
        int s = 0;
        for (int c = 1; c < n; c++) s += int'(bv[i][c] && !bv[i][c-1]);
        return s;
    endfunction

    function automatic int peak(input int i, input int n);
        int p = 0;
        for (int c = 0; c < n; c++) if (cv[i][c] > p) p = cv[i][c];
        return p;
    endfunction

    initial begin
        int base [2];
        int c;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_tx%0d", i), int'(tx_o[i]), 1);
            chk($sformatf("rst_busy%0d", i), int'(busy_o[i]), 0);
            chk($sformatf("rst_count%0d", i), int'(cnt_o[i]), 0);
            chk($sformatf("rst_ready%0d", i), int'(rdy_o[i]), 1);
        end
        #3 reset = 1'b0;
        repeat (3) @(negedge clock);

        // single 0xA5 frame
        stim = {8'hA5};
        run(130);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("a5_pre%0d", i), int'(wv[i][0]), 1);
            chk($sformatf("a5_start_first%0d", i), int'(wv[i][1]), 0);
            chk($sformatf("a5_start_last%0d", i), int'(wv[i][10]), 0);
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("a5_b%0d_first%0d", k, i), int'(wv[i][11 + 10*k]), a5[k]);
                chk($sformatf("a5_b%0d_last%0d", k, i), int'(wv[i][20 + 10*k]), a5[k]);
            end
            chk($sformatf("a5_stop%0d", i), int'(wv[i][91]), 1);
        end
        chk("a5_busy_len0", busy_sum(0, 130), 100);
        chk("a5_busy_len1", busy_sum(1, 130), 110);
        chk("a5_busy_first0", int'(bv[0][1]), 1);
        chk("a5_busy_last0", int'(bv[0][100]), 1);
        chk("a5_busy_end0", int'(bv[0][101]), 0);
        chk("a5_busy_end1", int'(bv[1][111]), 0);
        drain(300);
        chk("n_rx_a5_0", n_rx[0], 1);
        chk("n_rx_a5_1", n_rx[1], 1);

        // 0x81: long trailing high run exposes the stop length
        stim = {8'h81};
        run(130);
        chk("s81_high0", busy_high_sum(0, 130), 30);
        chk("s81_high1", busy_high_sum(1, 130), 40);
        chk("s81_len1", busy_sum(1, 130), 110);
        chk("s81_stop2_last", int'(wv[1][110] && bv[1][110]), 1);
        drain(300);

        // three back-to-back frames
        stim = {8'h00, 8'hFF, 8'h3C};
        run(400);
        chk("b2b_busy0", busy_sum(0, 400), 300);
        chk("b2b_busy1", busy_sum(1, 400), 330);
        chk("b2b_rises0", busy_rises(0, 400), 1);
        chk("b2b_rises1", busy_rises(1, 400), 1);
        chk("b2b_peak0", peak(0, 400), 2);
        chk("b2b_peak1", peak(1, 400), 2);
        chk("b2b_end_count0", cv[0][399], 0);
        drain(400);
        chk("n_rx_b2b_0", n_rx[0], 5);
        chk("n_rx_b2b_1", n_rx[1], 5);

        // hold in_valid with a new word every cycle while the line is busy
        base[0] = n_rx[0];
        base[1] = n_rx[1];
        @(negedge clock);
        #2;
        drv_data  = 8'h40;
        drv_valid = 1'b1;
        for (int cc = 0; cc < 130; cc++) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) cv[i][cc] = int'(cnt_o[i]);
            if (cc == 4) begin
                chk("full_count0", int'(cnt_o[0]), 4);
                chk("full_ready0", int'(rdy_o[0]), 0);
                chk("full_ready1", int'(rdy_o[1]), 0);
            end
            if (cc == 101) begin
                chk("full_pop_count0", int'(cnt_o[0]), 3);
                chk("full_pop_ready0", int'(rdy_o[0]), 1);
            end
            if (cc == 102) chk("refill_count0", int'(cnt_o[0]), 4);
            #2;
            drv_data = drv_data + 1'b1;
        end
        drv_valid = 1'b0;
        chk("full_peak0", peak(0, 130), 4);
        chk("full_peak1", peak(1, 130), 4);
        drain(1000);
        chk("n_rx_full0", n_rx[0] - base[0], 6);
        chk("n_rx_full1", n_rx[1] - base[1], 6);

        // asynchronous reset in the middle of 0x55's data bits, two words queued
        stim = {8'h55, 8'h01, 8'h02};
        run(40);
        chk("pre_rst_busy0", int'(bv[0][39]), 1);
        chk("pre_rst_count0", cv[0][39], 2);
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("async_tx%0d", i), int'(tx_o[i]), 1);
            chk($sformatf("async_busy%0d", i), int'(busy_o[i]), 0);
            chk($sformatf("async_count%0d", i), int'(cnt_o[i]), 0);
        end
        base[0] = n_rx[0];
        base[1] = n_rx[1];
        repeat (2) @(negedge clock);
        #3 reset = 1'b0;
        stim.delete();
        run(250);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("post_rst_busy%0d", i), busy_sum(i, 250), 0);
            chk($sformatf("post_rst_low%0d", i), low_sum(i, 250), 0);
            chk($sformatf("post_rst_rx%0d", i), n_rx[i] - base[i], 0);
        end
        stim = {8'h5A};
        run(130);
        drain(300);
        chk("n_rx_recover0", n_rx[0] - base[0], 1);
        chk("n_rx_recover1", n_rx[1] - base[1], 1);

        // push coinciding with a pop at three words buffered
        base[0] = n_rx[0];
        base[1] = n_rx[1];
        stim = {8'hC3, 8'h11, 8'h22, 8'h33};
        run(5);
        c = 0;
        while (!(act[0] && pos[0] == flen(0) - 1) && c < 200) begin
            @(negedge clock);
            c++;
        end
        chk("coincide_timeout", int'(c >= 200), 0);
        chk("coincide_pre_count0", int'(cnt_o[0]), 3);
        #2;
        drv_data  = 8'h44;
        drv_valid = 1'b1;
        @(negedge clock);
        chk("coincide_count0", int'(cnt_o[0]), 3);
        chk("coincide_count1", int'(cnt_o[1]), 4);
        #2;
        drv_valid = 1'b0;
        drain(800);
        chk("n_rx_coincide0", n_rx[0] - base[0], 5);
        chk("n_rx_coincide1", n_rx[1] - base[1], 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
